frame_segmenter: RTL and testbench

- Sits directly downstream of the pre-emphasis filter and consumes its 32-bit float sample stream (valid-only, no backpressure).
- Stores samples in a circular buffer and, once enough samples have arrived, replays the most recent FRAME_LEN samples as one contiguous, back-to-back frame burst. A new frame starts every HOP input samples (overlapping frames).
- Feeds the windowing/FFT stage. Data is opaque: no arithmetic is performed on sample values.

---
 rtl/frame_segmenter.sv | 128 ++++++++++++
 tb/tb_frame_segmenter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_segmenter.sv
// Circular-buffer frame segmenter: stores the input sample stream and replays the
// most recent FRAME_LEN samples as a back-to-back burst every HOP accepted samples.
module frame_segmenter #(
  parameter int unsigned FRAME_LEN = 256,
  parameter int unsigned HOP       = 128,
  localparam int unsigned ADDR_W   = $clog2(FRAME_LEN)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tvalid_input_stream,
  input  logic [31:0]       input_stream,
  output logic              tvalid_frame_stream,
  output logic [31:0]       frame_stream,
  output logic              frame_start,
  output logic              frame_end,
  output logic [ADDR_W-1:0] sample_index,
  output logic              overrun
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  typedef enum logic [1:0] {
    S_FILL,
    S_WAIT_HOP,
    S_READ
  } state_t;

  state_t             r_state, w_state;
  logic [ADDR_W-1:0]  r_wr_ptr, w_wr_ptr;
  logic [CNT_W-1:0]   r_fill_cnt, w_fill_cnt;
  logic [CNT_W-1:0]   r_hop_cnt, w_hop_cnt;
  logic [ADDR_W-1:0]  r_rd_base, w_rd_base;
  logic [CNT_W-1:0]   r_rd_k, w_rd_k;
  logic               r_overrun, w_overrun;
  logic               w_trigger;
  logic               w_rd_issue;
  logic [ADDR_W-1:0]  w_rd_addr;
  logic [31:0]        r_mem [FRAME_LEN];

  // READ lasts FRAME_LEN issue cycles plus one drain cycle in which frame_end is on the output.
  assign w_rd_issue = (r_state == S_READ) && (r_rd_k < CNT_W'(FRAME_LEN));
  assign w_rd_addr  = r_rd_base + r_rd_k[ADDR_W-1:0];
  assign overrun    = r_overrun;

  always_comb begin
    w_state    = r_state;
    w_wr_ptr   = r_wr_ptr;
    w_fill_cnt = r_fill_cnt;
    w_hop_cnt  = r_hop_cnt;
    w_rd_base  = r_rd_base;
    w_rd_k     = r_rd_k;
    w_overrun  = r_overrun;
    w_trigger  = 1'b0;

    if (tvalid_input_stream) begin
      w_wr_ptr = r_wr_ptr + ADDR_W'(1);
      if (r_state == S_FILL) begin
        w_fill_cnt = r_fill_cnt + CNT_W'(1);
        w_trigger  = (w_fill_cnt == CNT_W'(FRAME_LEN));
      end else if (r_hop_cnt + CNT_W'(1) == CNT_W'(HOP)) begin
        w_hop_cnt = '0;
        w_trigger = 1'b1;
      end else begin
        w_hop_cnt = r_hop_cnt + CNT_W'(1);
      end
    end

    // A trigger while busy is dropped and flagged; otherwise it launches a burst from the oldest sample.
    if (r_state == S_READ) begin
      if (r_rd_k == CNT_W'(FRAME_LEN)) begin
        w_state = S_WAIT_HOP;
      end else begin
        w_rd_k = r_rd_k + CNT_W'(1);
      end
      if (w_trigger) begin
        w_overrun = 1'b1;
      end
    end else if (w_trigger) begin
      w_state   = S_READ;
      w_rd_k    = '0;
      w_rd_base = r_wr_ptr + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_FILL;
      r_wr_ptr   <= '0;
      r_fill_cnt <= '0;
      r_hop_cnt  <= '0;
      r_rd_base  <= '0;
      r_rd_k     <= '0;
      r_overrun  <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_wr_ptr   <= w_wr_ptr;
      r_fill_cnt <= w_fill_cnt;
      r_hop_cnt  <= w_hop_cnt;
      r_rd_base  <= w_rd_base;
      r_rd_k     <= w_rd_k;
      r_overrun  <= w_overrun;
    end
  end

  // Sample storage; the registered read below sees the pre-write contents (read-first).
  always_ff @(posedge clk) begin
    if (tvalid_input_stream) begin
      r_mem[r_wr_ptr] <= input_stream;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tvalid_frame_stream <= 1'b0;
      frame_stream        <= '0;
      frame_start         <= 1'b0;
      frame_end           <= 1'b0;
      sample_index        <= '0;
    end else begin
      tvalid_frame_stream <= w_rd_issue;
      frame_stream        <= w_rd_issue ? r_mem[w_rd_addr] : 32'h0;
      frame_start         <= w_rd_issue && (r_rd_k == '0);
      frame_end           <= w_rd_issue && (r_rd_k == CNT_W'(FRAME_LEN - 1));
      sample_index        <= w_rd_issue ? r_rd_k[ADDR_W-1:0] : '0;
    end
  end

endmodule

// File: tb/tb_frame_segmenter.sv
// Bench for frame_segmenter: two instances (HOP=4 and HOP=8, FRAME_LEN=8) share one input
// stream and are checked every cycle against a sample-history model.
module tb_frame_segmenter;

  localparam int unsigned FL = 8;
  localparam int unsigned AW = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        tv = 1'b0;
  logic [31:0] din = 32'h0;

  logic          ov   [2];
  logic [31:0]   od   [2];
  logic          ofs  [2];
  logic          ofe  [2];
  logic          oovr [2];
  logic [AW-1:0] oidx [2];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    frame_segmenter #(.FRAME_LEN(FL), .HOP((g == 0) ? 4 : 8)) u_dut (
      .clk                 (clk),
      .rst_n               (rst_n),
      .tvalid_input_stream (tv),
      .input_stream        (din),
      .tvalid_frame_stream (ov[g]),
      .frame_stream        (od[g]),
      .frame_start         (ofs[g]),
      .frame_end           (ofe[g]),
      .sample_index        (oidx[g]),
      .overrun             (oovr[g])
    );
  end

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Model: accepted-sample history plus per-instance counters and an expected-output schedule.
  logic [31:0] hist [$];
  int          fill [2];
  int          hopc [2];
  int          busy_until [2];
  int          ovr_from [2];
  logic        ev [2][32];
  logic [31:0] ed [2][32];
  int          ek [2][32];

  function automatic int hop_of(input int i);
    return (i == 0) ? 4 : 8;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  task automatic model_clear();
    hist.delete();
    for (int i = 0; i < 2; i++) begin
      fill[i] = 0;
      hopc[i] = 0;
      busy_until[i] = -100;
      ovr_from[i] = -1;
      for (int s = 0; s < 32; s++) begin
        ev[i][s] = 1'b0;
        ed[i][s] = 32'h0;
        ek[i][s] = 0;
      end
    end
  endtask

  task automatic model_step(input logic [31:0] d);
    bit trig;
    hist.push_back(d);
    for (int i = 0; i < 2; i++) begin
      trig = 1'b0;
      if (fill[i] < FL) begin
        fill[i]++;
        trig = (fill[i] == FL);
      end else begin
        hopc[i]++;
        if (hopc[i] == hop_of(i)) begin
          hopc[i] = 0;
          trig = 1'b1;
        end
      end
      if (trig) begin
        if (cyc <= busy_until[i]) begin
          if (ovr_from[i] < 0) ovr_from[i] = cyc + 1;
        end else begin
          busy_until[i] = cyc + FL + 1;
          for (int k = 0; k < FL; k++) begin
            ev[i][(cyc + 2 + k) % 32] = 1'b1;
            ed[i][(cyc + 2 + k) % 32] = hist[hist.size() - FL + k];
            ek[i][(cyc + 2 + k) % 32] = k;
          end
        end
      end
    end
  endtask

  task automatic compare();
    int s;
    s = cyc % 32;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("valid[%0d]", i), 32'(ov[i]), 32'(ev[i][s]));
      chk($sformatf("overrun[%0d]", i), 32'(oovr[i]),
          32'((ovr_from[i] >= 0) && (cyc >= ovr_from[i])));
      if (ev[i][s]) begin
        chk($sformatf("data[%0d]", i), od[i], ed[i][s]);
        chk($sformatf("index[%0d]", i), 32'(oidx[i]), 32'(ek[i][s]));
        chk($sformatf("start[%0d]", i), 32'(ofs[i]), 32'(ek[i][s] == 0));
        chk($sformatf("end[%0d]", i), 32'(ofe[i]), 32'(ek[i][s] == FL - 1));
        ev[i][s] = 1'b0;
      end else begin
        chk($sformatf("idle_start[%0d]", i), 32'(ofs[i]), 32'h0);
        chk($sformatf("idle_end[%0d]", i), 32'(ofe[i]), 32'h0);
      end
    end
  endtask

  task automatic tick(input logic v, input logic [31:0] d);
    @(negedge clk);
    cyc++;
    compare();
    tv = v;
    din = d;
    if (v && rst_n) model_step(d);
  endtask

  task automatic feed(input int first, input int count, input int gap);
    for (int j = 0; j < count; j++) begin
      tick(1'b1, 32'(first + j));
      repeat (gap - 1) tick(1'b0, 32'h0);
    end
  endtask

  // Asserts reset (immediately, or at the next falling edge) and checks outputs clear at once.
  task automatic apply_reset(input bit at_edge);
    if (at_edge) begin
      @(negedge clk);
      cyc++;
      compare();
    end
    rst_n = 1'b0;
    tv = 1'b0;
    din = 32'h0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst_valid[%0d]", i), 32'(ov[i]), 32'h0);
      chk($sformatf("rst_data[%0d]", i), od[i], 32'h0);
      chk($sformatf("rst_start[%0d]", i), 32'(ofs[i]), 32'h0);
      chk($sformatf("rst_end[%0d]", i), 32'(ofe[i]), 32'h0);
      chk($sformatf("rst_index[%0d]", i), 32'(oidx[i]), 32'h0);
      chk($sformatf("rst_overrun[%0d]", i), 32'(oovr[i]), 32'h0);
    end
    model_clear();
    repeat (3) tick(1'b0, 32'h0);
    rst_n = 1'b1;
  endtask

  initial begin
    int  n;
    bit  found;
    model_clear();
    #1 rst_n = 1'b0;
    repeat (3) tick(1'b0, 32'h0);
    rst_n = 1'b1;

    // Fill: first frame 1..8
    for (int j = 1; j <= 8; j++) begin
      tick(1'b1, 32'(j));
      if (j == 8) begin
        chk("pin_f1_first", ed[0][(cyc + 2) % 32], 32'h1);
        chk("pin_f1_last", ed[0][(cyc + 9) % 32], 32'h8);
        chk("pin_f1_last_idx", 32'(ek[0][(cyc + 9) % 32]), 32'h7);
        chk("pin_f1_h8_first", ed[1][(cyc + 2) % 32], 32'h1);
      end
      repeat (9) tick(1'b0, 32'h0);
    end

    // Overlap: frames 5..12 and 9..16 (HOP=8 instance: 9..16 only)
    for (int j = 9; j <= 16; j++) begin
      tick(1'b1, 32'(j));
      if (j == 12) begin
        chk("pin_f2_first", ed[0][(cyc + 2) % 32], 32'h5);
        chk("pin_f2_last", ed[0][(cyc + 9) % 32], 32'hc);
        chk("pin_f2_h8_none", 32'(ev[1][(cyc + 2) % 32]), 32'h0);
      end
      if (j == 16) begin
        chk("pin_f3_first", ed[0][(cyc + 2) % 32], 32'h9);
        chk("pin_f3_h8_first", ed[1][(cyc + 2) % 32], 32'h9);
      end
      repeat (9) tick(1'b0, 32'h0);
    end

    // Write during read: 21,22 arrive while frame 13..20 is being replayed
    feed(17, 3, 10);
    tick(1'b1, 32'd20);
    chk("pin_wdr_last", ed[0][(cyc + 9) % 32], 32'd20);
    tick(1'b0, 32'h0);
    tick(1'b1, 32'd21);
    tick(1'b1, 32'd22);
    repeat (8) tick(1'b0, 32'h0);
    feed(23, 2, 10);

    // Continuous input: triggers land inside bursts
    for (int j = 0; j < 30; j++) tick(1'b1, 32'(25 + j));
    chk("pin_overrun_predicted", 32'(ovr_from[0] >= 0), 32'h1);

    // Reset mid-burst at k=3
    n = 55;
    found = 1'b0;
    for (int j = 0; j < 40 && !found; j++) begin
      tick(1'b1, 32'(n));
      n++;
      if (ov[0] && oidx[0] == 3'd3) found = 1'b1;
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL wait_k3 cyc=%0d actual=timeout expected=index3", cyc);
    end
    apply_reset(1'b0);

    // Refill after reset, then randomized traffic with occasional bursts
    feed(100, 7, 3);
    repeat (12) tick(1'b0, 32'h0);
    for (int j = 0; j < 400; j++) begin
      if (j < 200) tick($urandom_range(0, 5) == 0, $urandom);
      else         tick($urandom_range(0, 1) == 0, $urandom);
    end

    // Clean start for non-overlapping HOP=8 frames 1..8, 9..16, 17..24
    apply_reset(1'b1);
    for (int j = 1; j <= 24; j++) begin
      tick(1'b1, 32'(j));
      if (j == 24) chk("pin_h8_f3_first", ed[1][(cyc + 2) % 32], 32'd17);
      repeat (11) tick(1'b0, 32'h0);
    end
    repeat (20) tick(1'b0, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout cyc=%0d actual=running expected=finished", cyc);
    $fatal(1, "timeout");
  end

endmodule
